// File: rtl/rfarb_pkg.sv
// rtl/rfarb_pkg.sv - shared types and constants for the register-file debug arbiter
package rfarb_pkg;
    localparam int RFARB_XLEN   = 32;
    localparam int RFARB_REG_AW = 5;
    localparam int RFARB_X0     = 0;

    typedef enum logic [2:0] {
        RFARB_RUN,
        RFARB_DRAIN,
        RFARB_HALTED,
        RFARB_ACCESS,
        RFARB_RESUME
    } rfarb_state_t;
endpackage

// File: rtl/rfarb_drain_timer.sv
// rtl/rfarb_drain_timer.sv - drain cycle counter, built only with RFARB_DRAIN_TIMEOUT_EN
module rfarb_drain_timer #(
    parameter int DRAIN_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(DRAIN_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero outside DRAIN so every drain starts from a fresh count.
    assign cnt_d     = en_i ? cnt_q + CW'(1) : '0;
    assign expired_o = en_i && (cnt_q == CW'(DRAIN_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/regfile_dbg_arbiter.sv
// rtl/regfile_dbg_arbiter.sv - halts/drains the pipeline and grants debug access to the register file
// Optional drain timeout: RFARB_DRAIN_TIMEOUT_EN
module regfile_dbg_arbiter
    import rfarb_pkg::*;
#(
    parameter int XLEN      = RFARB_XLEN,
    parameter int REG_AW    = RFARB_REG_AW,
    parameter int DRAIN_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              pipe_empty_i,
    output logic              halt_req_o,
    output logic              halted_o,
    input  logic              dbg_halt_i,
    input  logic              dbg_resume_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    input  logic [XLEN-1:0]   dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [XLEN-1:0]   dbg_rdata_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_a3_o,
    output logic [XLEN-1:0]   rf_wd3_o,
    output logic              rf_a1_sel_o,
    output logic [REG_AW-1:0] rf_ra_o,
    input  logic [XLEN-1:0]   rf_rd1_i,
    output logic              wb_conflict_o
`ifdef RFARB_DRAIN_TIMEOUT_EN
    ,
    output logic              drain_timeout_o
`endif
);
    rfarb_state_t      state_q;
    logic              halt_req_q, halted_q, gnt_q, rvalid_q, conflict_q;
    logic [XLEN-1:0]   rdata_q;
    logic              acc_we_q;
    logic [REG_AW-1:0] acc_addr_q;
    logic [XLEN-1:0]   acc_wdata_q;
    logic              drain_expired;
    logic              acc_is_x0;

`ifdef RFARB_DRAIN_TIMEOUT_EN
    logic drain_timeout_q;

    rfarb_drain_timer #(.DRAIN_MAX(DRAIN_MAX)) u_drain_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == RFARB_DRAIN),
        .expired_o (drain_expired)
    );
    assign drain_timeout_o = drain_timeout_q;
`else
    logic unused_drain_max;
    assign unused_drain_max = (DRAIN_MAX > 0);
    assign drain_expired    = 1'b0;
`endif

    assign acc_is_x0 = (acc_addr_q == REG_AW'(RFARB_X0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RFARB_RUN;
            halt_req_q  <= 1'b0;
            halted_q    <= 1'b0;
            gnt_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            conflict_q  <= 1'b0;
            rdata_q     <= '0;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
`ifdef RFARB_DRAIN_TIMEOUT_EN
            drain_timeout_q <= 1'b0;
`endif
        end else begin
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
            if (wb_we_i && (state_q == RFARB_HALTED || state_q == RFARB_ACCESS))
                conflict_q <= 1'b1;
            case (state_q)
                RFARB_RUN: if (dbg_halt_i) begin
                    state_q    <= RFARB_DRAIN;
                    halt_req_q <= 1'b1;
                end
                RFARB_DRAIN: if (pipe_empty_i || drain_expired) begin
                    state_q  <= RFARB_HALTED;
                    halted_q <= 1'b1;
`ifdef RFARB_DRAIN_TIMEOUT_EN
                    if (!pipe_empty_i) drain_timeout_q <= 1'b1;
`endif
                end
                RFARB_HALTED: if (dbg_req_i) begin
                    state_q     <= RFARB_ACCESS;
                    gnt_q       <= 1'b1;
                    acc_we_q    <= dbg_we_i;
                    acc_addr_q  <= dbg_addr_i;
                    acc_wdata_q <= dbg_wdata_i;
                end else if (dbg_resume_i) begin
                    state_q    <= RFARB_RESUME;
                    halt_req_q <= 1'b0;
                    halted_q   <= 1'b0;
`ifdef RFARB_DRAIN_TIMEOUT_EN
                    drain_timeout_q <= 1'b0;
`endif
                end
                RFARB_ACCESS: begin
                    state_q <= RFARB_HALTED;
                    if (!acc_we_q) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= acc_is_x0 ? '0 : rf_rd1_i;
                    end
                end
                RFARB_RESUME: state_q <= RFARB_RUN;
                default:      state_q <= RFARB_RUN;
            endcase
        end
    end

    // Writeback always owns the write port when it writes; debug writes fill idle slots only.
    always_comb begin
        rf_we_o  = wb_we_i;
        rf_a3_o  = wb_rd_i;
        rf_wd3_o = wb_data_i;
        if (state_q == RFARB_ACCESS && acc_we_q && !wb_we_i) begin
            rf_we_o  = !acc_is_x0;
            rf_a3_o  = acc_addr_q;
            rf_wd3_o = acc_wdata_q;
        end
    end

    assign rf_a1_sel_o   = (state_q == RFARB_ACCESS) && !acc_we_q;
    assign rf_ra_o       = rf_a1_sel_o ? acc_addr_q : '0;
    assign halt_req_o    = halt_req_q;
    assign halted_o      = halted_q;
    assign dbg_gnt_o     = gnt_q;
    assign dbg_rvalid_o  = rvalid_q;
    assign dbg_rdata_o   = rdata_q;
    assign wb_conflict_o = conflict_q;
endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// tb/tb_regfile_dbg_arbiter.sv - scoreboard bench for regfile_dbg_arbiter
module tb_regfile_dbg_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        pipe_empty_i;
    logic        halt_req_o, halted_o;
    logic        dbg_halt_i, dbg_resume_i, dbg_req_i, dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        rf_we_o;
    logic [4:0]  rf_a3_o;
    logic [31:0] rf_wd3_o;
    logic        rf_a1_sel_o;
    logic [4:0]  rf_ra_o;
    logic [31:0] rf_rd1_i;
    logic        wb_conflict_o;
`ifdef RFARB_DRAIN_TIMEOUT_EN
    logic        drain_timeout_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rf_mem[32];

    regfile_dbg_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .pipe_empty_i(pipe_empty_i), .halt_req_o(halt_req_o), .halted_o(halted_o),
        .dbg_halt_i(dbg_halt_i), .dbg_resume_i(dbg_resume_i), .dbg_req_i(dbg_req_i),
        .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .rf_we_o(rf_we_o), .rf_a3_o(rf_a3_o), .rf_wd3_o(rf_wd3_o),
        .rf_a1_sel_o(rf_a1_sel_o), .rf_ra_o(rf_ra_o), .rf_rd1_i(rf_rd1_i),
        .wb_conflict_o(wb_conflict_o)
`ifdef RFARB_DRAIN_TIMEOUT_EN
        , .drain_timeout_o(drain_timeout_o)
`endif
    );

    always #5 clk = ~clk;

    // Register file model; x0 holds junk so the arbiter's own x0 handling is exercised.
    assign rf_rd1_i = rf_mem[rf_a1_sel_o ? rf_ra_o : 5'd1];
    always @(posedge clk) if (rf_we_o) rf_mem[rf_a3_o] <= rf_wd3_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rf_we_o === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write_addr", {27'd0, rf_a3_o}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_wr.pop_front();
                check("write_addr", {27'd0, rf_a3_o}, {27'd0, e[36:32]});
                check("write_data", rf_wd3_o, e[31:0]);
            end
        end
        if (dbg_rvalid_o === 1'b1) begin
            if (exp_rd.size() == 0) check("unexpected_rvalid", dbg_rdata_o, 32'hFFFF_FFFF);
            else check("read_data", dbg_rdata_o, exp_rd.pop_front());
        end
    end

    task automatic dbg_op(input string name, input logic we, input logic [4:0] addr, input logic [31:0] wd);
        dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
        tick();
        check({name, "_gnt"}, {31'd0, dbg_gnt_o}, 32'd1);
        dbg_req_i = 1'b0;
        tick();
        check({name, "_rvalid"}, {31'd0, dbg_rvalid_o}, {31'd0, !we});
        check({name, "_gnt_drop"}, {31'd0, dbg_gnt_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;
        rf_mem[0] = 32'h0000_BAD0;
        rst = 1'b1; wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0; pipe_empty_i = 0;
        dbg_halt_i = 0; dbg_resume_i = 0; dbg_req_i = 0; dbg_we_i = 0;
        dbg_addr_i = 0; dbg_wdata_i = 0;
        tick(); tick();
        check("rst_outputs", {26'd0, halt_req_o, halted_o, dbg_gnt_o, dbg_rvalid_o, rf_we_o, wb_conflict_o}, 32'd0);
        check("rst_rdata", dbg_rdata_o, 32'd0);
        rst = 1'b0;
        tick();

        // Writeback pass-through in RUN
        exp_wr.push_back({5'd5, 32'h0000_A5A5});
        wb_we_i = 1; wb_rd_i = 5; wb_data_i = 32'h0000_A5A5;
        #1 check("run_passthrough_we", {31'd0, rf_we_o}, 32'd1);
        check("run_halt_req", {31'd0, halt_req_o}, 32'd0);
        tick();
        wb_we_i = 0;

        // Halt and drain
        dbg_halt_i = 1;
        tick();
        check("drain_halt_req", {31'd0, halt_req_o}, 32'd1);
        dbg_halt_i = 0;
        tick(); tick(); tick();
        check("drain_not_halted", {31'd0, halted_o}, 32'd0);
        pipe_empty_i = 1;
        tick();
        check("halted", {31'd0, halted_o}, 32'd1);

        // Debug write/read, x0 corner cases
        exp_wr.push_back({5'd7, 32'hDEAD_BEEF});
        dbg_op("wr_x7", 1'b1, 5'd7, 32'hDEAD_BEEF);
        exp_rd.push_back(32'hDEAD_BEEF);
        dbg_op("rd_x7", 1'b0, 5'd7, 32'd0);
        dbg_op("wr_x0", 1'b1, 5'd0, 32'h1234_5678);
        exp_rd.push_back(32'd0);
        dbg_op("rd_x0", 1'b0, 5'd0, 32'd0);
        tick();
        check("rdata_held", dbg_rdata_o, 32'd0);
        check("no_conflict_yet", {31'd0, wb_conflict_o}, 32'd0);

        // Writeback collides with a debug write
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 3; dbg_wdata_i = 32'h0000_3333;
        tick();
        check("conflict_gnt", {31'd0, dbg_gnt_o}, 32'd1);
        dbg_req_i = 0;
        exp_wr.push_back({5'd9, 32'h0000_9999});
        wb_we_i = 1; wb_rd_i = 9; wb_data_i = 32'h0000_9999;
        tick();
        wb_we_i = 0;
        check("conflict_sticky", {31'd0, wb_conflict_o}, 32'd1);
        exp_rd.push_back(32'h0000_0103);
        dbg_op("rd_x3", 1'b0, 5'd3, 32'd0);

        // Access and resume together: access first, then RESUME, then RUN
        exp_rd.push_back(32'h0000_9999);
        dbg_resume_i = 1;
        dbg_op("rd_x9_resume", 1'b0, 5'd9, 32'd0);
        check("still_halted_after_access", {31'd0, halted_o}, 32'd1);
        tick();
        check("resume_halt_req", {31'd0, halt_req_o}, 32'd0);
        check("resume_halted", {31'd0, halted_o}, 32'd0);
        dbg_resume_i = 0;
        tick();
        check("run_after_resume", {30'd0, halt_req_o, halted_o}, 32'd0);
        check("conflict_survives_resume", {31'd0, wb_conflict_o}, 32'd1);

        // Reset in the middle of a debug write
        dbg_halt_i = 1;
        tick();
        dbg_halt_i = 0;
        tick();
        check("rehalted", {31'd0, halted_o}, 32'd1);
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 12; dbg_wdata_i = 32'h0000_CAFE;
        tick();
        rst = 1; dbg_req_i = 0;
        #1;
        check("rst_mid_we", {31'd0, rf_we_o}, 32'd0);
        check("rst_mid_outputs", {27'd0, halt_req_o, halted_o, dbg_gnt_o, dbg_rvalid_o, wb_conflict_o}, 32'd0);
        check("rst_mid_rdata", dbg_rdata_o, 32'd0);
        tick();
        rst = 0;
        tick();
        check("post_rst_run", {31'd0, halt_req_o}, 32'd0);
        check("x12_untouched", rf_mem[12], 32'h0000_010C);

`ifdef RFARB_DRAIN_TIMEOUT_EN
        pipe_empty_i = 0;
        dbg_halt_i = 1;
        tick();
        dbg_halt_i = 0;
        for (int i = 0; i < 15; i++) tick();
        check("timeout_not_yet", {31'd0, halted_o}, 32'd0);
        tick();
        check("timeout_halted", {31'd0, halted_o}, 32'd1);
        check("timeout_flag", {31'd0, drain_timeout_o}, 32'd1);
        dbg_resume_i = 1;
        tick();
        dbg_resume_i = 0;
        check("timeout_cleared", {31'd0, drain_timeout_o}, 32'd0);
        tick();
`endif

        tick(); tick();
        check("pending_writes", exp_wr.size(), 32'd0);
        check("pending_reads", exp_rd.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
